// File: rtl/dvp_pkg.sv
// Shared GPIO block definitions: local register offsets, edge-mode encoding and edge matcher.
package dvp_pkg;

    localparam int GPIO_N_CH_MAX = 16;

    localparam logic [4:0] GPIO_IN_OFS   = 5'h00;
    localparam logic [4:0] GPIO_STS_OFS  = 5'h04;
    localparam logic [4:0] GPIO_ENB_OFS  = 5'h08;
    localparam logic [4:0] GPIO_EDGE_OFS = 5'h0C;
    localparam logic [4:0] GPIO_OUT_OFS  = 5'h10;
    localparam logic [4:0] GPIO_DEB_OFS  = 5'h14;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    function automatic logic edge_match(edge_mode_t mode, logic level, logic prev);
        case (mode)
            EDGE_RISE: return level & ~prev;
            EDGE_FALL: return ~level & prev;
            EDGE_BOTH: return level ^ prev;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// One GPIO input channel: synchroniser, optional debounce filter (GPIO_DEBOUNCE_EN), edge detector.
module gpio_sync_edge
    import dvp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  edge_mode_t       mode,
`ifdef GPIO_DEBOUNCE_EN
    input  logic [DEB_W-1:0] deb,
`endif
    output logic             level,
    output logic             edge_hit
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   synced;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
        end
    end

    assign synced = sync_reg[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [DEB_W-1:0] cnt_reg;
    logic             filt_reg;

    // cnt_reg counts consecutive cycles the synced input disagrees with the filtered level;
    // any return to agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            filt_reg <= 1'b0;
        end else if ((deb == '0) || (synced == filt_reg)) begin
            cnt_reg  <= '0;
            filt_reg <= synced;
        end else if (cnt_reg == deb) begin
            cnt_reg  <= '0;
            filt_reg <= synced;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    assign level = (deb == '0) ? synced : filt_reg;
`else
    assign level = synced;
`endif

    // prev_reg is never cleared on mode changes so a new edge mode cannot fire spuriously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= level;
        end
    end

    assign edge_hit = edge_match(mode, level, prev_reg);

endmodule

// File: rtl/gpio_capture.sv
// GPIO input-capture / output block: register file, sticky W1C status, level interrupt, read mux.
// Optional per-channel input debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_capture
    import dvp_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8
) (
    input  logic            s00_axi_aclk,
    input  logic            s00_axi_aresetn,
    input  logic [N_CH-1:0] gpio_in,
    output logic [N_CH-1:0] gpio_out,
    input  logic            reg_wr,
    input  logic            reg_rd,
    input  logic [4:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    output logic            reg_rvld,
    output logic            intr
);

    logic [N_CH-1:0]   sts_reg;
    logic [N_CH-1:0]   enb_reg;
    logic [2*N_CH-1:0] edge_reg;
    logic [N_CH-1:0]   out_reg;
    logic              intr_reg;
    logic [31:0]       rdata_reg;
    logic              rvld_reg;
`ifdef GPIO_DEBOUNCE_EN
    logic [DEB_W-1:0]  deb_reg;
`endif

    logic [N_CH-1:0]   level;
    logic [N_CH-1:0]   edge_hit;
    logic [N_CH-1:0]   w1c;
    logic [31:0]       rd_mux;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            gpio_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_W       (DEB_W)
            ) u_sync_edge (
                .clk      (s00_axi_aclk),
                .rst_n    (s00_axi_aresetn),
                .din      (gpio_in[gi]),
                .mode     (edge_mode_t'(edge_reg[2*gi +: 2])),
`ifdef GPIO_DEBOUNCE_EN
                .deb      (deb_reg),
`endif
                .level    (level[gi]),
                .edge_hit (edge_hit[gi])
            );
        end
    endgenerate

    assign w1c = (reg_wr && (reg_addr == GPIO_STS_OFS)) ? reg_wdata[N_CH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            GPIO_IN_OFS:   rd_mux = 32'(level);
            GPIO_STS_OFS:  rd_mux = 32'(sts_reg);
            GPIO_ENB_OFS:  rd_mux = 32'(enb_reg);
            GPIO_EDGE_OFS: rd_mux = 32'(edge_reg);
            GPIO_OUT_OFS:  rd_mux = 32'(out_reg);
`ifdef GPIO_DEBOUNCE_EN
            GPIO_DEB_OFS:  rd_mux = 32'(deb_reg);
`endif
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            sts_reg   <= '0;
            enb_reg   <= '0;
            edge_reg  <= {N_CH{2'b01}};
            out_reg   <= '0;
            intr_reg  <= 1'b0;
            rdata_reg <= '0;
            rvld_reg  <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
            deb_reg   <= '0;
`endif
        end else begin
            // Capture has priority over a coincident W1C so no edge is ever lost.
            sts_reg  <= (sts_reg & ~w1c) | edge_hit;
            intr_reg <= |(sts_reg & enb_reg);
            rvld_reg <= reg_rd;
            if (reg_rd) begin
                rdata_reg <= rd_mux;
            end
            if (reg_wr) begin
                case (reg_addr)
                    GPIO_ENB_OFS:  enb_reg  <= reg_wdata[N_CH-1:0];
                    GPIO_EDGE_OFS: edge_reg <= reg_wdata[2*N_CH-1:0];
                    GPIO_OUT_OFS:  out_reg  <= reg_wdata[N_CH-1:0];
`ifdef GPIO_DEBOUNCE_EN
                    GPIO_DEB_OFS:  deb_reg  <= reg_wdata[DEB_W-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    assign gpio_out  = out_reg;
    assign intr      = intr_reg;
    assign reg_rdata = rdata_reg;
    assign reg_rvld  = rvld_reg;

endmodule

// File: tb/tb_gpio_capture.sv
// Self-checking bench for gpio_capture: directed register/capture scenarios plus random traffic
// against a delay-line reference model of the capture path.
module tb_gpio_capture;
    import dvp_pkg::*;

    localparam int N_CH        = 8;
    localparam int SYNC_STAGES = 2;
    localparam int DEB_W       = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [4:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        reg_rvld;
    logic        intr;

    gpio_capture #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_W       (DEB_W)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .gpio_in         (gpio_in),
        .gpio_out        (gpio_out),
        .reg_wr          (reg_wr),
        .reg_rd          (reg_rd),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .reg_rvld        (reg_rvld),
        .intr            (intr)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  sts_m, enb_m, out_m, deb_m;
    logic [15:0] edge_m;
    logic        intr_m, rvld_m;
    logic [31:0] rdata_m;
    logic [7:0]  hist[$];   // hist[k] = input applied k+1 cycles ago
    bit          model_on = 1'b1;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sts_m = '0; enb_m = '0; out_m = '0; deb_m = '0;
        edge_m = 16'h5555; intr_m = 1'b0; rvld_m = 1'b0; rdata_m = '0;
        hist = {};
        for (int k = 0; k <= SYNC_STAGES; k++) hist.push_back(8'h00);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            GPIO_IN_OFS:   return {24'd0, hist[SYNC_STAGES-1]};
            GPIO_STS_OFS:  return {24'd0, sts_m};
            GPIO_ENB_OFS:  return {24'd0, enb_m};
            GPIO_EDGE_OFS: return {16'd0, edge_m};
            GPIO_OUT_OFS:  return {24'd0, out_m};
`ifdef GPIO_DEBOUNCE_EN
            GPIO_DEB_OFS:  return {24'd0, deb_m};
`endif
            default:       return 32'd0;
        endcase
    endfunction

    // The level seen by edge detection is the input from SYNC_STAGES cycles back,
    // compared with the one a cycle earlier.
    function automatic logic [7:0] model_hits();
        logic [7:0] cur;
        logic [7:0] old;
        logic [7:0] h;
        cur = hist[SYNC_STAGES-1];
        old = hist[SYNC_STAGES];
        h = '0;
        for (int c = 0; c < N_CH; c++) begin
            case (edge_m[2*c +: 2])
                2'b01:   h[c] = cur[c] & ~old[c];
                2'b10:   h[c] = ~cur[c] & old[c];
                2'b11:   h[c] = cur[c] ^ old[c];
                default: h[c] = 1'b0;
            endcase
        end
        return h;
    endfunction

    task automatic tick();
        logic [7:0] hits;
        logic [7:0] w1c;
        logic       nintr;
        @(posedge clk);
        if (rst_n) begin
            hits  = model_hits();
            w1c   = (reg_wr && reg_addr == GPIO_STS_OFS) ? reg_wdata[7:0] : 8'h00;
            nintr = |(sts_m & enb_m);
            if (reg_rd) rdata_m = model_read(reg_addr);
            rvld_m = reg_rd;
            sts_m  = (sts_m & ~w1c) | hits;
            if (reg_wr) begin
                case (reg_addr)
                    GPIO_ENB_OFS:  enb_m  = reg_wdata[7:0];
                    GPIO_EDGE_OFS: edge_m = reg_wdata[15:0];
                    GPIO_OUT_OFS:  out_m  = reg_wdata[7:0];
`ifdef GPIO_DEBOUNCE_EN
                    GPIO_DEB_OFS:  deb_m  = reg_wdata[7:0];
`endif
                    default: ;
                endcase
            end
            intr_m = nintr;
            hist.push_front(gpio_in);
            void'(hist.pop_back());
        end
        #1;
        if (model_on && rst_n) begin
            chk("intr", {31'd0, intr}, {31'd0, intr_m});
            chk("gpio_out", {24'd0, gpio_out}, {24'd0, out_m});
            chk("rvld", {31'd0, reg_rvld}, {31'd0, rvld_m});
            if (rvld_m) chk("rdata", reg_rdata, rdata_m);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_wr = 1'b0;
        $display("wr  addr=0x%02h data=0x%08h", a, d);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        reg_rd = 1'b1; reg_addr = a;
        tick();
        reg_rd = 1'b0;
        d = reg_rdata;
        $display("rd  addr=0x%02h data=0x%08h", a, d);
    endtask

    task automatic pulse(input logic [7:0] v);
        gpio_in = v;
        tick();
        gpio_in = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] d;
    logic [4:0]  ra;
    int          idx;
    logic [4:0]  addr_tab [7] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18};

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        chk("rst_intr", {31'd0, intr}, 32'd0);
        chk("rst_rvld", {31'd0, reg_rvld}, 32'd0);
        chk("rst_rdata", reg_rdata, 32'd0);
        rst_n = 1'b1;
        tick();
        rd(GPIO_EDGE_OFS, d); chk("rst_edge", d, 32'h0000_5555);
        rd(GPIO_STS_OFS, d);  chk("rst_sts", d, 32'd0);
        rd(GPIO_IN_OFS, d);   chk("rst_in", d, 32'd0);

        // Rise capture: STS sets SYNC_STAGES+1 edges after the pulse is applied
        wr(GPIO_ENB_OFS, 32'h01);
        pulse(8'h01);
        tick();
        rd(GPIO_STS_OFS, d); chk("rise_early", d, 32'h00);
        rd(GPIO_STS_OFS, d); chk("rise_sts", d, 32'h01);
        chk("rise_intr", {31'd0, intr}, 32'd1);
        wr(GPIO_STS_OFS, 32'h01);
        rd(GPIO_STS_OFS, d); chk("w1c_sts", d, 32'h00);
        chk("w1c_intr", {31'd0, intr}, 32'd0);

        // Fall on ch1 is one cycle later; ch0 off ignores its pulse
        wr(GPIO_EDGE_OFS, 32'h0008);
        pulse(8'h03);
        tick();
        tick();
        rd(GPIO_STS_OFS, d); chk("fall_early", d, 32'h00);
        rd(GPIO_STS_OFS, d); chk("fall_sts", d, 32'h02);
        wr(GPIO_STS_OFS, 32'h02);
        wr(GPIO_EDGE_OFS, 32'h5555);

        // W1C coinciding with an edge hit: set wins
        pulse(8'h01);
        tick();
        wr(GPIO_STS_OFS, 32'h01);
        rd(GPIO_STS_OFS, d); chk("collision", d, 32'h01);
        wr(GPIO_STS_OFS, 32'h01);

        // ENB does not gate capture; intr follows ENB one cycle later
        wr(GPIO_ENB_OFS, 32'h00);
        pulse(8'h08);
        repeat (3) tick();
        rd(GPIO_STS_OFS, d); chk("mask_sts", d, 32'h08);
        chk("mask_intr", {31'd0, intr}, 32'd0);
        wr(GPIO_ENB_OFS, 32'h08);
        chk("enb_intr_lag", {31'd0, intr}, 32'd0);
        tick();
        chk("enb_intr", {31'd0, intr}, 32'd1);
        wr(GPIO_OUT_OFS, 32'hA5);
        chk("gpio_out", {24'd0, gpio_out}, 32'hA5);
        rd(GPIO_OUT_OFS, d); chk("out_rd", d, 32'hA5);

        // Ignored writes, unmapped reads, concurrent write+read
        wr(GPIO_IN_OFS, 32'hFF);
        rd(GPIO_IN_OFS, d); chk("in_ro", d, 32'h00);
        rd(5'h18, d); chk("unmapped", d, 32'h00);
`ifndef GPIO_DEBOUNCE_EN
        wr(GPIO_DEB_OFS, 32'hFF);
        rd(GPIO_DEB_OFS, d); chk("deb_absent", d, 32'h00);
`endif
        reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = GPIO_ENB_OFS; reg_wdata = 32'h3C;
        tick();
        reg_wr = 1'b0; reg_rd = 1'b0;
        chk("wr_rd_old", reg_rdata, 32'h08);
        rd(GPIO_ENB_OFS, d); chk("wr_rd_new", d, 32'h3C);

        // Random traffic checked every cycle against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
            idx = int'($urandom_range(0, 3));
            reg_wr = idx[0];
            reg_rd = idx[1];
            ra = addr_tab[$urandom_range(0, 6)];
            if (reg_wr && ra == GPIO_DEB_OFS) ra = 5'h18;
            reg_addr = ra;
            reg_wdata = $urandom;
            if (reg_wr) $display("wr  addr=0x%02h data=0x%08h (random)", reg_addr, reg_wdata);
            if (reg_rd) $display("rd  addr=0x%02h (random)", reg_addr);
            tick();
            reg_wr = 1'b0; reg_rd = 1'b0;
        end
        gpio_in = '0;
        repeat (4) tick();
        rd(GPIO_STS_OFS, d); chk("rand_sts", d, {24'd0, sts_m});

        // Async reset mid-operation
        wr(GPIO_OUT_OFS, 32'hFF);
        wr(GPIO_ENB_OFS, 32'hFF);
        pulse(8'h01);
        repeat (3) tick();
        rd(GPIO_OUT_OFS, d);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gpio_out", {24'd0, gpio_out}, 32'd0);
        chk("arst_intr", {31'd0, intr}, 32'd0);
        chk("arst_rdata", reg_rdata, 32'd0);
        chk("arst_rvld", {31'd0, reg_rvld}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulse(8'h01);
        tick();
        rd(GPIO_STS_OFS, d); chk("arst_first_early", d, 32'h00);
        rd(GPIO_STS_OFS, d); chk("arst_first_edge", d, 32'h01);

`ifdef GPIO_DEBOUNCE_EN
        model_on = 1'b0;
        wr(GPIO_DEB_OFS, 32'h04);
        wr(GPIO_STS_OFS, 32'hFF);
        gpio_in = 8'h04;
        repeat (3) tick();
        gpio_in = '0;
        repeat (10) tick();
        rd(GPIO_STS_OFS, d); chk("deb_glitch_sts", d, 32'h00);
        rd(GPIO_IN_OFS, d);  chk("deb_glitch_in", d, 32'h00);
        gpio_in = 8'h04;
        repeat (8) tick();
        rd(GPIO_IN_OFS, d);  chk("deb_hold_in", d, 32'h04);
        gpio_in = '0;
        repeat (12) tick();
        rd(GPIO_STS_OFS, d); chk("deb_hold_sts", d, 32'h04);
        wr(GPIO_STS_OFS, 32'hFF);
        gpio_in = 8'h04;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("deb_arst_intr", {31'd0, intr}, 32'd0);
        gpio_in = '0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_on = 1'b1;
        repeat (10) tick();
        rd(GPIO_STS_OFS, d); chk("deb_arst_sts", d, 32'h00);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
